seg7_scan_capture: RTL and testbench
====================================

Name: seg7_scan_capture

Overview:
- Receiving end of the multiplexed 7-segment display interface driven by top_fsm_div (AN, CATH).
- Samples the scanned anode/cathode lines, waits for each digit dwell to settle, and decodes each cathode pattern back to a hex nibble.
- Assembles a full 8-digit frame and publishes it with a one-cycle valid pulse.
- Sits beside the display driver in the VIO top, so software reads numeric results instead of raw segments.

Parameters:
- NUM_DIGITS, 8: number of anodes scanned; also the width of AN.
- SETTLE_CYCLES, 4: consecutive synchronized cycles AN and CATH must hold before a capture; legal range 1..255.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- AN  input  NUM_DIGITS  anode lines, active-low, one-hot-low when a digit is lit.
- CATH  input  7  cathode lines, active-low, bit0=a … bit6=g.
- digits  output  4*NUM_DIGITS  decoded frame; nibble i belongs to AN[i].
- digit_ok  output  NUM_DIGITS  bit i is 1 if digit i decoded to a legal hex glyph.
- frame_valid  output  1  one-cycle pulse when digits/digit_ok update.
- an_err  output  1  sticky; set on any multi-zero AN sample.

Behaviour:
- Reset (async, active-high): digits=0, digit_ok=0, frame_valid=0, an_err=0, seen mask=0, working registers=0, settle counter=0, captured flag=0, sync stages=all ones.
- Synchronization: AN and CATH each pass through a 2-stage register. All logic below uses the stage-2 values (an_s, cath_s).
- Settle counter:
  - Clears to 0 and clears the captured flag whenever {an_s, cath_s} differs from the previous cycle.
  - Otherwise increments, saturating at SETTLE_CYCLES.
- Capture:
  - Fires in the cycle the counter reaches SETTLE_CYCLES-1 while captured=0 and an_s has exactly one zero bit (index k).
  - Writes work_nib[k] and work_ok[k], sets seen[k], and sets captured. This gives one capture per dwell.
  - Latency from a stable input change to capture is 2 + SETTLE_CYCLES cycles.
- AN classification:
  - an_s all ones (blanking between digits): no capture, no error.
  - Two or more zeros: no capture; an_err set and held until reset.
- Decode (active-low, g..a), pattern to nibble:
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3
  - 0011001→4, 0010010→5, 0000010→6, 1111000→7
  - 0000000→8, 0010000→9, 0001000→A, 0000011→b
  - 1000110→C, 0100001→d, 0000110→E, 0001110→F
  - Any other pattern, including blank 1111111: nibble=0, ok=0.
- Frame completion:
  - In the cycle after the capture that makes seen all ones, work_nib/work_ok are copied to digits/digit_ok.
  - frame_valid=1 for exactly that cycle, and seen clears in the same cycle.
- Repeated digit: a digit captured again before the frame completes overwrites its working value; seen is unchanged.
- Simultaneous events: a capture in the same cycle as the frame copy lands in the new frame. Its seen bit is set after the clear, and the copy uses pre-capture working values.
- Outputs are held between frames. frame_valid is never asserted two cycles in a row.
- Reset mid-frame discards the partial frame; the next frame starts from an empty seen mask.

Decomposition:
- Package seg7_pkg holds:
  - the 16 cathode-pattern localparams (SEG_0 … SEG_F) and SEG_BLANK;
  - the CATH bit-order constants;
  - a function onehot_low_index returning {valid, index}.
- Sub-module seg7_pattern_decode: purely combinational, cath[6:0] → {ok, nib[3:0]}, reusable by other display benches.

Test Plan:
- Scan 0x1234ABCD: AN walks 11111110…01111111, each dwell 16 cycles with 4 blank cycles between → one frame_valid, digits=32'h1234ABCD (digit0=D), digit_ok=8'hFF.
- Glitch filter: CATH toggles for 2 cycles inside a dwell with SETTLE_CYCLES=4 → glitch value never captured, final stable value captured once.
- Illegal glyph: digit 3 shows 1010101 → digit_ok=8'hF7, nibble 3 = 0, frame still completes.
- AN=11110011 held 10 cycles → an_err=1 and stays 1, no capture. A subsequent clean frame still publishes.
- Partial frame then reset: 5 digits scanned, reset pulsed → frame_valid stays 0. The next full scan of 0x00000007 yields digits=32'h00000007.
- Repeated digit: digit 0 shown as 5 then 9 before digits 1..7 → published nibble 0 = 9, exactly one frame_valid pulse.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for 7-segment scan decoding: glyph patterns, cathode bit order,
// and the one-hot-low anode helper.
package seg7_pkg;

    localparam int MAX_DIGITS = 32;

    // Cathode bit positions, active-low, a is the LSB.
    typedef enum int {
        CATH_A = 0,
        CATH_B = 1,
        CATH_C = 2,
        CATH_D = 3,
        CATH_E = 4,
        CATH_F = 5,
        CATH_G = 6
    } cath_bit_e;

    // Glyph patterns written g..a, active-low.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef struct packed {
        logic       valid;
        logic [4:0] index;
    } onehot_t;

    // valid only when exactly one bit is low; index is the position of that bit.
    function automatic onehot_t onehot_low_index(input logic [MAX_DIGITS-1:0] vec);
        onehot_t r;
        int      zeros;
        r     = '0;
        zeros = 0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (!vec[i]) begin
                zeros++;
                r.index = 5'(i);
            end
        end
        r.valid = (zeros == 1);
        return r;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of an active-low 7-segment cathode pattern back to a hex nibble.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] cath,
    output logic       ok,
    output logic [3:0] nib
);

    always_comb begin
        // NOTE: assigning defaults before the case keeps every path driven, so no latch is inferred.
        ok  = 1'b0;
        nib = 4'h0;
        case (cath[CATH_G:CATH_A])
            SEG_0:     begin ok = 1'b1; nib = 4'h0; end
            SEG_1:     begin ok = 1'b1; nib = 4'h1; end
            SEG_2:     begin ok = 1'b1; nib = 4'h2; end
            SEG_3:     begin ok = 1'b1; nib = 4'h3; end
            SEG_4:     begin ok = 1'b1; nib = 4'h4; end
            SEG_5:     begin ok = 1'b1; nib = 4'h5; end
            SEG_6:     begin ok = 1'b1; nib = 4'h6; end
            SEG_7:     begin ok = 1'b1; nib = 4'h7; end
            SEG_8:     begin ok = 1'b1; nib = 4'h8; end
            SEG_9:     begin ok = 1'b1; nib = 4'h9; end
            SEG_A:     begin ok = 1'b1; nib = 4'hA; end
            SEG_B:     begin ok = 1'b1; nib = 4'hB; end
            SEG_C:     begin ok = 1'b1; nib = 4'hC; end
            SEG_D:     begin ok = 1'b1; nib = 4'hD; end
            SEG_E:     begin ok = 1'b1; nib = 4'hE; end
            SEG_F:     begin ok = 1'b1; nib = 4'hF; end
            SEG_BLANK: begin ok = 1'b0; nib = 4'h0; end
            default:   begin ok = 1'b0; nib = 4'h0; end
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Captures a multiplexed 7-segment scan (AN/CATH) and republishes it as a decoded
// hex frame with a one-cycle valid pulse.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_DIGITS-1:0]   AN,
    input  logic [6:0]              CATH,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_ok,
    output logic                    frame_valid,
    output logic                    an_err
);

    localparam logic [7:0] SETTLE_MAX  = 8'(SETTLE_CYCLES);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    logic [NUM_DIGITS-1:0]   an_m, an_s, an_p;
    logic [6:0]              cath_m, cath_s, cath_p;
    logic [7:0]              cnt, cnt_next;
    logic                    captured;
    logic [NUM_DIGITS-1:0]   seen, seen_next;
    logic [4*NUM_DIGITS-1:0] work_nib;
    logic [NUM_DIGITS-1:0]   work_ok;

    logic                    changed, capture, multi_zero, complete;
    logic [MAX_DIGITS-1:0]   an_pad;
    onehot_t                 oh;
    logic                    dec_ok;
    logic [3:0]              dec_nib;

    seg7_pattern_decode u_decode (
        .cath (cath_s),
        .ok   (dec_ok),
        .nib  (dec_nib)
    );

    always_comb begin
        changed = (an_s != an_p) || (cath_s != cath_p);

        an_pad                 = '1;
        an_pad[NUM_DIGITS-1:0] = an_s;
        oh                     = onehot_low_index(an_pad);
        multi_zero             = !oh.valid && !(&an_s);

        cnt_next = cnt;
        if (changed) begin
            cnt_next = '0;
        end else if (cnt < SETTLE_MAX) begin
            cnt_next = cnt + 8'd1;
        end

        // A change clears the captured flag in the same cycle, so it must not block this capture.
        capture  = (cnt_next == SETTLE_LAST) && (changed || !captured) && oh.valid;
        // Gating on frame_valid keeps the pulse from ever repeating on back-to-back cycles.
        complete = (&seen) && !frame_valid;

        seen_next = complete ? '0 : seen;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (capture && (int'(oh.index) == i)) begin
                seen_next[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_m        <= '1;
            an_s        <= '1;
            an_p        <= '1;
            cath_m      <= '1;
            cath_s      <= '1;
            cath_p      <= '1;
            cnt         <= '0;
            captured    <= 1'b0;
            seen        <= '0;
            work_nib    <= '0;
            work_ok     <= '0;
            digits      <= '0;
            digit_ok    <= '0;
            frame_valid <= 1'b0;
            an_err      <= 1'b0;
        end else begin
            // NOTE: non-blocking updates let the frame copy read working values from before this cycle's capture.
            an_m        <= AN;
            an_s        <= an_m;
            an_p        <= an_s;
            cath_m      <= CATH;
            cath_s      <= cath_m;
            cath_p      <= cath_s;
            cnt         <= cnt_next;
            captured    <= capture || (captured && !changed);
            seen        <= seen_next;
            an_err      <= an_err || multi_zero;
            frame_valid <= complete;

            if (complete) begin
                digits   <= work_nib;
                digit_ok <= work_ok;
            end

            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (capture && (int'(oh.index) == i)) begin
                    work_nib[i*4 +: 4] <= dec_nib;
                    work_ok[i]         <= dec_ok;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: drives scanned AN/CATH sequences and
// scoreboards the published frames.
module tb_seg7_scan_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  AN;
    logic [6:0]  CATH;
    logic [31:0] digits;
    logic [7:0]  digit_ok;
    logic        frame_valid;
    logic        an_err;

    int tests  = 0;
    int failed = 0;

    logic [39:0] obs[$];
    logic [39:0] exp_q[$];
    int          rd       = 0;
    int          fv_twice = 0;
    logic        fv_prev  = 1'b0;

    seg7_scan_capture #(.NUM_DIGITS(8), .SETTLE_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .AN          (AN),
        .CATH        (CATH),
        .digits      (digits),
        .digit_ok    (digit_ok),
        .frame_valid (frame_valid),
        .an_err      (an_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) obs.push_back({digit_ok, digits});
        if (frame_valid && fv_prev) fv_twice++;
        fv_prev = frame_valid;
    end

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        assert (observed === expected) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge and hold for the given cycles.
    task automatic hold(input logic [7:0] an, input logic [6:0] c, input int cycles);
        AN   = an;
        CATH = c;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic show(input int k, input logic [6:0] c);
        hold(~(8'b1 << k), c, 16);
        hold(8'hFF, 7'h7F, 4);
    endtask

    task automatic scan(input logic [31:0] val);
        for (int k = 0; k < 8; k++) show(k, glyph(val[k*4 +: 4]));
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) begin
            int waited = 0;
            while (obs.size() <= rd && waited < 100) begin
                @(posedge clk);
                #1;
                waited++;
            end
            if (obs.size() <= rd) begin
                check({tag, "_timeout"}, 64'(obs.size()), 64'(rd + 1));
                void'(exp_q.pop_front());
            end else begin
                check(tag, obs[rd], exp_q.pop_front());
                rd++;
            end
        end
        repeat (10) @(posedge clk);
        #1;
        check({tag, "_count"}, 64'(obs.size()), 64'(rd));
    endtask

    initial begin
        reset = 1'b1;
        AN    = 8'hFF;
        CATH  = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        check("reset_digits", 64'(digits), 64'h0);
        check("reset_ok", 64'(digit_ok), 64'h0);
        check("reset_fv", 64'(frame_valid), 64'h0);
        check("reset_an_err", 64'(an_err), 64'h0);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Basic frame.
        exp_q.push_back({8'hFF, 32'h1234ABCD});
        scan(32'h1234ABCD);
        drain("frame_1234abcd");
        check("held_digits", 64'(digits), 64'h1234ABCD);

        // Short glitches inside digit 2's dwell must not be captured.
        exp_q.push_back({8'hFF, 32'h89ABC6EF});
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                hold(8'hFB, glyph(4'hE), 2);
                hold(8'hFB, glyph(4'h3), 2);
                hold(8'hFB, glyph(4'h6), 16);
                hold(8'hFF, 7'h7F, 4);
            end else begin
                show(k, glyph(4'(32'h89ABC6EF >> (k*4))));
            end
        end
        drain("glitch_filter");

        // Illegal glyph on digit 3.
        exp_q.push_back({8'hF7, 32'h76540210});
        for (int k = 0; k < 8; k++) begin
            if (k == 3) show(k, 7'b1010101);
            else        show(k, glyph(4'(32'h76543210 >> (k*4))));
        end
        drain("illegal_glyph");

        // Two anodes low: sticky error, no capture.
        check("an_err_before", 64'(an_err), 64'h0);
        hold(8'b11110011, glyph(4'h8), 10);
        hold(8'hFF, 7'h7F, 4);
        check("an_err_set", 64'(an_err), 64'h1);
        check("an_err_no_frame", 64'(obs.size()), 64'(rd));
        repeat (20) @(posedge clk);
        #1;
        check("an_err_sticky", 64'(an_err), 64'h1);
        exp_q.push_back({8'hFF, 32'hCAFEF00D});
        scan(32'hCAFEF00D);
        drain("after_an_err");
        check("an_err_still", 64'(an_err), 64'h1);

        // Partial frame discarded by reset.
        for (int k = 0; k < 5; k++) show(k, glyph(4'h9));
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("partial_no_frame", 64'(obs.size()), 64'(rd));
        check("partial_reset_digits", 64'(digits), 64'h0);
        check("partial_reset_an_err", 64'(an_err), 64'h0);
        exp_q.push_back({8'hFF, 32'h00000007});
        scan(32'h00000007);
        drain("after_reset");

        // Digit 0 shown twice before the frame completes; last value wins.
        show(0, glyph(4'h5));
        check("repeat_no_early_frame", 64'(obs.size()), 64'(rd));
        exp_q.push_back({8'hFF, 32'h31415929});
        scan(32'h31415929);
        drain("repeat_digit");

        check("fv_never_back_to_back", 64'(fv_twice), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
